// File: rtl/morse_msg_sequencer.sv
// Morse message sequencer: buffers letter codes and paces them to a keyer.
// Optional macro MORSE_SEQ_LOOP_EN replays the buffer continuously.
module morse_msg_sequencer #(
    parameter int UNIT_CYCLES = 25000000,
    parameter int DEPTH       = 8
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       wr_en,
    input  logic [4:0] wr_code,
    input  logic       go,
    input  logic       abort,
    input  logic       key_busy,
    output logic       key_start,
    output logic [4:0] key_code,
    output logic       full,
    output logic       empty,
    output logic       tx_active,
    output logic [2:0] state,
    output logic [7:0] sent_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_KEY   = 3'd2,
        S_GAP_LETTER = 3'd3,
        S_GAP_WORD   = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [4:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            seen_busy_q, seen_busy_d;
    logic [UW-1:0]   cyc_q, cyc_d;
    logic [2:0]      unit_q, unit_d;
    logic [7:0]      sent_q, sent_d;
`ifdef MORSE_SEQ_LOOP_EN
    logic [CW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   idx_nxt;
    logic            wrapped;
    logic            last_q, last_d;
`endif

    logic [AW-1:0]   head_addr;
    logic [4:0]      head;
    logic            is_letter;
    logic            is_space;
    logic            push;
    logic            pop;
    logic            fire;
    logic            gap_done;
    logic            in_gap;

`ifdef MORSE_SEQ_LOOP_EN
    assign head_addr = rd_ptr_q + idx_q[AW-1:0];
    assign idx_nxt   = idx_q + 1'b1;
    assign wrapped   = (idx_nxt >= count_q);
`else
    assign head_addr = rd_ptr_q;
`endif

    assign head      = mem_q[head_addr];
    assign is_letter = (head <= 5'd25);
    assign is_space  = (head == 5'd31);
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push      = wr_en && !full && !abort;
    assign fire      = (state_q == S_ISSUE) && is_letter
                       && !abort && !RESET;
    assign in_gap    = (state_q == S_GAP_LETTER)
                       || (state_q == S_GAP_WORD);
    assign gap_done  = (cyc_q == UW'(UNIT_CYCLES - 1))
                       && (unit_q == ((state_q == S_GAP_WORD)
                                      ? 3'd6 : 3'd2));

    // State register
    always_ff @(posedge CLOCK_50) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (go && !empty) state_d = S_ISSUE;
                end
                S_ISSUE: begin
                    if (is_letter) begin
                        state_d = S_WAIT_KEY;
                    end else if (is_space) begin
                        state_d = S_GAP_WORD;
                    end else begin
`ifdef MORSE_SEQ_LOOP_EN
                        state_d = S_ISSUE;
`else
                        state_d = (count_q > CW'(1) || push)
                                  ? S_ISSUE : S_IDLE;
`endif
                    end
                end
                S_WAIT_KEY: begin
                    if (seen_busy_q && !key_busy) begin
`ifdef MORSE_SEQ_LOOP_EN
                        state_d = last_q ? S_GAP_WORD : S_GAP_LETTER;
`else
                        state_d = S_GAP_LETTER;
`endif
                    end
                end
                S_GAP_LETTER, S_GAP_WORD: begin
                    if (gap_done) begin
`ifdef MORSE_SEQ_LOOP_EN
                        state_d = S_ISSUE;
`else
                        state_d = (!empty || push) ? S_ISSUE : S_IDLE;
`endif
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Outputs decoded from current state and head entry
    always_comb begin
        key_start = fire;
        key_code  = fire ? head : 5'd0;
        tx_active = (state_q != S_IDLE);
        state     = state_q;
    end

    // Buffer pointers, gap timer, busy tracking and letter counter
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        seen_busy_d = 1'b0;
        cyc_d       = '0;
        unit_d      = '0;
        sent_d      = sent_q + {7'd0, fire};
        pop         = 1'b0;
`ifdef MORSE_SEQ_LOOP_EN
        idx_d       = idx_q;
        last_d      = last_q;
        if (state_q == S_IDLE && state_d == S_ISSUE) begin
            idx_d = '0;
        end
        if (state_q == S_ISSUE && !abort) begin
            if (is_letter) begin
                idx_d  = idx_nxt;
                last_d = wrapped;
            end else if (is_space) begin
                idx_d  = idx_nxt;
            end else begin
                idx_d  = wrapped ? '0 : idx_nxt;
            end
        end
        if (in_gap && gap_done && !abort) begin
            last_d = 1'b0;
            if (idx_q >= count_q) idx_d = '0;
        end
`else
        pop = (state_q == S_ISSUE) && !abort;
`endif
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
        if (state_q == S_WAIT_KEY) begin
            seen_busy_d = seen_busy_q | key_busy;
        end
        if (in_gap && state_d == state_q) begin
            if (cyc_q == UW'(UNIT_CYCLES - 1)) begin
                cyc_d  = '0;
                unit_d = unit_q + 3'd1;
            end else begin
                cyc_d  = cyc_q + 1'b1;
                unit_d = unit_q;
            end
        end
        if (abort) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            seen_busy_d = 1'b0;
`ifdef MORSE_SEQ_LOOP_EN
            idx_d       = '0;
            last_d      = 1'b0;
`endif
        end
    end

    // Datapath registers
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            seen_busy_q <= 1'b0;
            cyc_q       <= '0;
            unit_q      <= '0;
            sent_q      <= '0;
`ifdef MORSE_SEQ_LOOP_EN
            idx_q       <= '0;
            last_q      <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            seen_busy_q <= seen_busy_d;
            cyc_q       <= cyc_d;
            unit_q      <= unit_d;
            sent_q      <= sent_d;
`ifdef MORSE_SEQ_LOOP_EN
            idx_q       <= idx_d;
            last_q      <= last_d;
`endif
        end
    end

    // Message storage; contents need no reset since pointers gate reads
    always_ff @(posedge CLOCK_50) begin
        if (push && !RESET) mem_q[wr_ptr_q] <= wr_code;
    end

    assign sent_count = sent_q;

endmodule

// File: tb/tb_morse_msg_sequencer.sv
// Directed testbench for morse_msg_sequencer (UNIT_CYCLES=4, DEPTH=4).
// Keyer model holds key_busy for 10 cycles after each key_start.
module tb_morse_msg_sequencer;

    logic       clk = 1'b0;
    logic       RESET = 1'b1;
    logic       wr_en = 1'b0;
    logic [4:0] wr_code = 5'd0;
    logic       go = 1'b0;
    logic       abort = 1'b0;
    logic       key_busy;
    logic       key_start;
    logic [4:0] key_code;
    logic       full;
    logic       empty;
    logic       tx_active;
    logic [2:0] state;
    logic [7:0] sent_count;

    int errors = 0;
    int checks = 0;

    int ks_q[$];
    int gap_q[$];
    int kind_q[$];
    int run = 0;
    int run_kind = 0;
    int consec = 0;
    logic prev_ks = 1'b0;
    int busy_cnt = 0;

    morse_msg_sequencer #(.UNIT_CYCLES(4), .DEPTH(4)) dut (
        .CLOCK_50(clk), .RESET(RESET), .wr_en(wr_en),
        .wr_code(wr_code), .go(go), .abort(abort),
        .key_busy(key_busy), .key_start(key_start),
        .key_code(key_code), .full(full), .empty(empty),
        .tx_active(tx_active), .state(state),
        .sent_count(sent_count)
    );

    always #5 clk = ~clk;

    // Keyer model
    always @(posedge clk) begin
        if (RESET)          busy_cnt <= 0;
        else if (key_start) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign key_busy = (busy_cnt != 0);

    // Monitor: key_start codes and gap run lengths
    always @(negedge clk) begin
        if (key_start) begin
            ks_q.push_back(int'(key_code));
            if (prev_ks) consec <= consec + 1;
        end
        prev_ks <= key_start;
        if (state == 3'd3 || state == 3'd4) begin
            run <= run + 1;
            run_kind <= int'(state);
        end else if (run != 0) begin
            gap_q.push_back(run);
            kind_q.push_back(run_kind);
            run <= 0;
        end
    end

    function automatic int ks_at(input int i);
        return (i < ks_q.size()) ? ks_q[i] : -1;
    endfunction

    function automatic int gap_at(input int i);
        return (i < gap_q.size()) ? gap_q[i] : -1;
    endfunction

    function automatic int kind_at(input int i);
        return (i < kind_q.size()) ? kind_q[i] : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int code);
        wr_en = 1'b1;
        wr_code = 5'(code);
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_go();
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_idle(input int max);
        int n = 0;
        while (state !== 3'd0 && n < max) begin
            tick();
            n++;
        end
        checks++;
        if (state !== 3'd0) begin
            $display("FAIL idle_timeout: state=%0d want 0", state);
            errors++;
        end
        tick();
        tick();
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) tick();
        checks += 7;
        if (state !== 3'd0) begin
            $display("FAIL rst_state: got %0d want 0", state); errors++;
        end
        if (empty !== 1'b1) begin
            $display("FAIL rst_empty: got %0b want 1", empty); errors++;
        end
        if (full !== 1'b0) begin
            $display("FAIL rst_full: got %0b want 0", full); errors++;
        end
        if (key_start !== 1'b0) begin
            $display("FAIL rst_ks: got %0b want 0", key_start); errors++;
        end
        if (key_code !== 5'd0) begin
            $display("FAIL rst_kc: got %0d want 0", key_code); errors++;
        end
        if (tx_active !== 1'b0) begin
            $display("FAIL rst_tx: got %0b want 0", tx_active); errors++;
        end
        if (sent_count !== 8'd0) begin
            $display("FAIL rst_cnt: got %0d want 0", sent_count); errors++;
        end
        RESET = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_two_letters();
        int b = ks_q.size();
        int g = gap_q.size();
        wr(0);
        wr(19);
        checks++;
        if (empty !== 1'b0) begin
            $display("FAIL two_notempty: got %0b want 0", empty); errors++;
        end
        pulse_go();
        wait_idle(300);
        checks += 9;
        if (ks_q.size() != b + 2) begin
            $display("FAIL two_nks: got %0d want 2", ks_q.size() - b);
            errors++;
        end
        if (ks_at(b) != 0) begin
            $display("FAIL two_code0: got %0d want 0", ks_at(b)); errors++;
        end
        if (ks_at(b + 1) != 19) begin
            $display("FAIL two_code1: got %0d want 19", ks_at(b + 1));
            errors++;
        end
        if (gap_at(g) != 12) begin
            $display("FAIL two_gap0: got %0d want 12", gap_at(g)); errors++;
        end
        if (gap_at(g + 1) != 12) begin
            $display("FAIL two_gap1: got %0d want 12", gap_at(g + 1));
            errors++;
        end
        if (kind_at(g + 1) != 3) begin
            $display("FAIL two_kind: got %0d want 3", kind_at(g + 1));
            errors++;
        end
        if (sent_count !== 8'd2) begin
            $display("FAIL two_cnt: got %0d want 2", sent_count); errors++;
        end
        if (empty !== 1'b1) begin
            $display("FAIL two_empty: got %0b want 1", empty); errors++;
        end
        if (consec != 0) begin
            $display("FAIL two_consec: got %0d want 0", consec); errors++;
        end
    endtask

    task automatic test_word_gap();
        int b = ks_q.size();
        int g = gap_q.size();
        wr(0);
        wr(31);
        wr(4);
        pulse_go();
        wait_idle(400);
        checks += 7;
        if (ks_q.size() != b + 2) begin
            $display("FAIL word_nks: got %0d want 2", ks_q.size() - b);
            errors++;
        end
        if (ks_at(b) != 0 || ks_at(b + 1) != 4) begin
            $display("FAIL word_codes: got %0d,%0d want 0,4",
                     ks_at(b), ks_at(b + 1));
            errors++;
        end
        if (gap_at(g) != 12) begin
            $display("FAIL word_gapl: got %0d want 12", gap_at(g)); errors++;
        end
        if (gap_at(g + 1) != 28) begin
            $display("FAIL word_gapw: got %0d want 28", gap_at(g + 1));
            errors++;
        end
        if (kind_at(g + 1) != 4) begin
            $display("FAIL word_kind: got %0d want 4", kind_at(g + 1));
            errors++;
        end
        if (gap_at(g + 2) != 12) begin
            $display("FAIL word_gapl2: got %0d want 12", gap_at(g + 2));
            errors++;
        end
        if (sent_count !== 8'd4) begin
            $display("FAIL word_cnt: got %0d want 4", sent_count); errors++;
        end
    endtask

    task automatic test_full();
        int b = ks_q.size();
        wr(1);
        wr(2);
        wr(3);
        checks++;
        if (full !== 1'b0) begin
            $display("FAIL full_3: got %0b want 0", full); errors++;
        end
        wr(4);
        checks++;
        if (full !== 1'b1) begin
            $display("FAIL full_4: got %0b want 1", full); errors++;
        end
        wr(5);
        pulse_go();
        wait_idle(500);
        checks += 2;
        if (ks_q.size() != b + 4) begin
            $display("FAIL full_nks: got %0d want 4", ks_q.size() - b);
            errors++;
        end
        if (ks_at(b) != 1 || ks_at(b + 1) != 2 ||
            ks_at(b + 2) != 3 || ks_at(b + 3) != 4) begin
            $display("FAIL full_codes: got %0d,%0d,%0d,%0d want 1,2,3,4",
                     ks_at(b), ks_at(b + 1), ks_at(b + 2), ks_at(b + 3));
            errors++;
        end
    endtask

    task automatic test_abort();
        int b;
        int n = 0;
        wr(7);
        wr(8);
        pulse_go();
        while (state !== 3'd2 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (state !== 3'd2) begin
            $display("FAIL abort_reach: state=%0d want 2", state); errors++;
        end
        b = ks_q.size();
        abort = 1'b1;
        go = 1'b1;
        wr_en = 1'b1;
        wr_code = 5'd9;
        tick();
        abort = 1'b0;
        go = 1'b0;
        wr_en = 1'b0;
        checks += 4;
        if (state !== 3'd0) begin
            $display("FAIL abort_state: got %0d want 0", state); errors++;
        end
        if (empty !== 1'b1) begin
            $display("FAIL abort_empty: got %0b want 1", empty); errors++;
        end
        if (tx_active !== 1'b0) begin
            $display("FAIL abort_tx: got %0b want 0", tx_active); errors++;
        end
        if (sent_count !== 8'd9) begin
            $display("FAIL abort_cnt: got %0d want 9", sent_count); errors++;
        end
        repeat (40) tick();
        checks++;
        if (ks_q.size() != b || state !== 3'd0) begin
            $display("FAIL abort_quiet: ks=%0d state=%0d want 0,0",
                     ks_q.size() - b, state);
            errors++;
        end
    endtask

    task automatic test_reset_mid_gap();
        int n = 0;
        wr(10);
        wr(11);
        pulse_go();
        while (state !== 3'd3 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (state !== 3'd3) begin
            $display("FAIL rgap_reach: state=%0d want 3", state); errors++;
        end
        RESET = 1'b1;
        tick();
        checks += 6;
        if (state !== 3'd0) begin
            $display("FAIL rgap_state: got %0d want 0", state); errors++;
        end
        if (empty !== 1'b1 || full !== 1'b0) begin
            $display("FAIL rgap_buf: empty=%0b full=%0b want 1,0",
                     empty, full);
            errors++;
        end
        if (key_start !== 1'b0) begin
            $display("FAIL rgap_ks: got %0b want 0", key_start); errors++;
        end
        if (key_code !== 5'd0) begin
            $display("FAIL rgap_kc: got %0d want 0", key_code); errors++;
        end
        if (tx_active !== 1'b0) begin
            $display("FAIL rgap_tx: got %0b want 0", tx_active); errors++;
        end
        if (sent_count !== 8'd0) begin
            $display("FAIL rgap_cnt: got %0d want 0", sent_count); errors++;
        end
        RESET = 1'b0;
        repeat (20) tick();
        checks++;
        if (state !== 3'd0 || empty !== 1'b1) begin
            $display("FAIL rgap_stay: state=%0d empty=%0b want 0,1",
                     state, empty);
            errors++;
        end
    endtask

    task automatic test_invalid();
        int b = ks_q.size();
        wr(27);
        wr(2);
        pulse_go();
        wait_idle(300);
        checks += 3;
        if (ks_q.size() != b + 1) begin
            $display("FAIL inv_nks: got %0d want 1", ks_q.size() - b);
            errors++;
        end
        if (ks_at(b) != 2) begin
            $display("FAIL inv_code: got %0d want 2", ks_at(b)); errors++;
        end
        if (sent_count !== 8'd1) begin
            $display("FAIL inv_cnt: got %0d want 1", sent_count); errors++;
        end
        pulse_go();
        checks++;
        if (tx_active !== 1'b0) begin
            $display("FAIL empty_go: tx_active=%0b want 0", tx_active);
            errors++;
        end
        repeat (3) tick();
        checks++;
        if (tx_active !== 1'b0) begin
            $display("FAIL empty_go2: tx_active=%0b want 0", tx_active);
            errors++;
        end
    endtask

    task automatic test_loop();
        int b = ks_q.size();
        int g = gap_q.size();
        int n = 0;
        wr(0);
        wr(1);
        pulse_go();
        while (ks_q.size() < b + 4 && n < 400) begin
            tick();
            n++;
        end
        checks += 6;
        if (ks_q.size() < b + 4) begin
            $display("FAIL loop_nks: got %0d want 4", ks_q.size() - b);
            errors++;
        end
        if (ks_at(b) != 0 || ks_at(b + 1) != 1 ||
            ks_at(b + 2) != 0 || ks_at(b + 3) != 1) begin
            $display("FAIL loop_codes: got %0d,%0d,%0d,%0d want 0,1,0,1",
                     ks_at(b), ks_at(b + 1), ks_at(b + 2), ks_at(b + 3));
            errors++;
        end
        if (gap_at(g) != 12) begin
            $display("FAIL loop_gap0: got %0d want 12", gap_at(g)); errors++;
        end
        if (gap_at(g + 1) != 28 || kind_at(g + 1) != 4) begin
            $display("FAIL loop_gapw: got %0d/%0d want 28/4",
                     gap_at(g + 1), kind_at(g + 1));
            errors++;
        end
        if (gap_at(g + 2) != 12) begin
            $display("FAIL loop_gap2: got %0d want 12", gap_at(g + 2));
            errors++;
        end
        if (sent_count !== 8'd4) begin
            $display("FAIL loop_cnt: got %0d want 4", sent_count); errors++;
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        b = ks_q.size();
        checks += 2;
        if (state !== 3'd0) begin
            $display("FAIL loop_abort: state=%0d want 0", state); errors++;
        end
        if (empty !== 1'b1) begin
            $display("FAIL loop_empty: got %0b want 1", empty); errors++;
        end
        repeat (80) tick();
        checks++;
        if (ks_q.size() != b) begin
            $display("FAIL loop_quiet: got %0d want 0", ks_q.size() - b);
            errors++;
        end
    endtask

    initial begin
        tick();
        test_reset();
`ifdef MORSE_SEQ_LOOP_EN
        test_loop();
`else
        test_two_letters();
        test_word_gap();
        test_full();
        test_abort();
        test_reset_mid_gap();
        test_invalid();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/morse_msg_sequencer.md
MORSE_MSG_SEQUENCER -- requirements
Module: morse_msg_sequencer

Interface
REQ-001 SHALL have parameter UNIT_CYCLES, default 25000000, meaning CLOCK_50 cycles per Morse time unit (0.5 s).
REQ-002 SHALL have parameter DEPTH, default 8, meaning message buffer entries (power of two, 2..16).
REQ-003 SHALL have port CLOCK_50  in  1  system clock; the block uses one clock.
REQ-004 SHALL have port RESET  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port wr_en  in  1  write strobe for one buffer entry.
REQ-006 SHALL have port wr_code  in  5  entry code: 0..25 = letters A..Z, 31 = word space, 26..30 = invalid.
REQ-007 SHALL have port go  in  1  start-transmission request.
REQ-008 SHALL have port abort  in  1  stop the transmission and flush the buffer.
REQ-009 SHALL have port key_busy  in  1  keyer is sounding a letter.
REQ-010 SHALL have port key_start  out  1  one-cycle keyer start pulse.
REQ-011 SHALL have port key_code  out  5  letter code for the keyer, valid while key_start is high.
REQ-012 SHALL have ports full and empty  out  1 each  buffer status.
REQ-013 SHALL have port tx_active  out  1  high whenever state is not IDLE.
REQ-014 SHALL have port state  out  3  current state encoding, for the LEDG debug display.
REQ-015 SHALL have port sent_count  out  8  letters issued, modulo 256.

Function
REQ-016 The buffer SHALL be a FIFO of DEPTH 5-bit entries: a write is accepted when wr_en=1 and full=0, and is ignored when full=1, even if a pop occurs in the same cycle.
REQ-017 The block SHALL use states IDLE=0, ISSUE=1, WAIT_KEY=2, GAP_LETTER=3 and GAP_WORD=4.
REQ-018 IDLE SHALL move to ISSUE on go=1 when empty=0; go SHALL be ignored when the buffer is empty or the state is not IDLE.
REQ-019 ISSUE SHALL take exactly one cycle and examine the head entry:
- letter: drive key_start=1 with key_code=entry, increment sent_count, go to WAIT_KEY;
- code 31: go to GAP_WORD with no key_start;
- codes 26..30: discard the entry and go to ISSUE, or to IDLE if no entries remain.
REQ-020 WAIT_KEY SHALL set an internal seen_busy flag once key_busy=1 is sampled.
REQ-021 WAIT_KEY SHALL go to GAP_LETTER on the first cycle with seen_busy=1 and key_busy=0.
REQ-022 GAP_LETTER SHALL last exactly 3*UNIT_CYCLES cycles and GAP_WORD exactly 7*UNIT_CYCLES cycles, timed by a unit counter cleared on gap entry.
REQ-023 At the end of a gap, the block SHALL go to ISSUE if entries remain, otherwise to IDLE.
REQ-024 The current entry SHALL be consumed (popped) in the ISSUE cycle.
REQ-025 abort=1 in any state SHALL force IDLE on the next edge, flush the buffer (empty=1), drive key_start=0 and clear seen_busy.
REQ-026 abort SHALL take priority over go and over wr_en in the same cycle.
REQ-027 key_start SHALL never be high in two consecutive cycles.
REQ-028 sent_count SHALL wrap from 255 to 0.

Reset
REQ-029 While RESET=1 at a clock edge, the block SHALL set state=IDLE, buffer empty (empty=1, full=0), key_start=0, key_code=0, tx_active=0, sent_count=0, unit counter=0 and seen_busy=0.
REQ-030 RESET SHALL take priority over abort, go and wr_en.
REQ-031 RESET mid-transmission SHALL discard all entries and return to IDLE on the next edge.

Configuration
REQ-032 With macro MORSE_SEQ_LOOP_EN defined, ISSUE SHALL advance a read pointer without discarding entries.
REQ-033 With MORSE_SEQ_LOOP_EN defined, after the last entry's gap the read pointer SHALL rewind to the oldest entry.
REQ-034 With MORSE_SEQ_LOOP_EN defined, the final gap before a rewind SHALL be GAP_WORD (7 units) when the last entry is a letter.
REQ-035 With MORSE_SEQ_LOOP_EN defined, transmission SHALL repeat until abort or RESET.
REQ-036 With MORSE_SEQ_LOOP_EN defined, invalid entries SHALL be skipped, not discarded, and writes during transmission SHALL join the loop.
REQ-037 Without MORSE_SEQ_LOOP_EN, entries SHALL be popped per REQ-024 and the block SHALL return to IDLE when the buffer is exhausted.

Verification (UNIT_CYCLES=4, DEPTH=4)
REQ-038 Write codes 0, 19 then go, with keyer model busy for 10 cycles after each start -> key_start pulses carry 0 then 19, 12-cycle gap after each busy fall, then IDLE, sent_count=2, empty=1.
REQ-039 Write 0, 31, 4 then go -> GAP_WORD lasts 28 cycles with no key_start, and exactly two key_start pulses occur.
REQ-040 Five writes with no pop -> full=1 after the 4th write, the 5th write is ignored, and four letters are transmitted.
REQ-041 abort in WAIT_KEY with go and wr_en asserted in the same cycle -> IDLE next cycle, empty=1, no further key_start; RESET mid-GAP_LETTER -> all outputs at reset values.
REQ-042 Write code 27 then 2, then go -> a single key_start with key_code=2; go while empty -> tx_active stays 0.
REQ-043 With MORSE_SEQ_LOOP_EN defined, write 0, 1 then go -> sequence 0, 1, 28-cycle gap, 0, 1 repeats; abort stops it and flushes.
